// File: rtl/fetch_if_id_if.sv
// Fetch-stage bus bundle: hazard-unit controls, ID-stage redirect, instruction memory
// and the IF/ID register outputs. The master modport belongs to the fetch stage.
interface fetch_if_id_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16
);
  // Hazard unit
  logic [1:0]         stall_c;
  logic               wrt_IF_ID;
  // ID-stage redirect
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  // Instruction memory
  logic [INSTR_W-1:0] imem_data;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  // IF/ID register and stage status
  logic [INSTR_W-1:0] instr_IF_ID;
  logic [PC_W-1:0]    pc_inc_IF_ID;
  logic               valid_IF_ID;
  logic               bubble_ID;
  logic               halt_fetch;

  modport master (
    input  stall_c, wrt_IF_ID, br_taken, br_target, imem_data,
    output imem_addr, imem_en, instr_IF_ID, pc_inc_IF_ID, valid_IF_ID, bubble_ID, halt_fetch
  );

  modport slave (
    output stall_c, wrt_IF_ID, br_taken, br_target, imem_data,
    input  imem_addr, imem_en, instr_IF_ID, pc_inc_IF_ID, valid_IF_ID, bubble_ID, halt_fetch
  );
endinterface

// File: rtl/fetch_if_id.sv
// Fetch stage and IF/ID pipeline register of the 16-bit RISC core. Owns the PC, runs
// multi-cycle hazard stalls, applies ID-stage redirects and stops fetching on HALT.
module fetch_if_id #(
  parameter int unsigned         PC_W      = 16,
  parameter int unsigned         INSTR_W   = 16,
  parameter logic [PC_W-1:0]     RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 16'h0800
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_if_id_if.master        bus
);

  localparam logic [4:0] OpHalt = 5'b00000;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [1:0]         scnt_q, scnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_inc_q, pc_inc_d;
  logic               valid_q, valid_d;
  logic               halt_q, halt_d;

  logic               stall_now;
  logic [1:0]         stall_len;
  logic [PC_W-1:0]    pc_plus2;
  logic               is_halt;

  // Stall detection and the combinational bus outputs.
  always_comb begin
    stall_now     = (scnt_q != 2'd0) | ~bus.wrt_IF_ID;
    stall_len     = (bus.stall_c == 2'b00) ? 2'd1 : bus.stall_c;
    pc_plus2      = pc_q + PC_W'(2);
    is_halt       = (bus.imem_data[INSTR_W-1 -: 5] == OpHalt);
    bus.imem_addr = pc_q;
    bus.imem_en   = ~rst & ~halt_q & ~stall_now;
    bus.bubble_ID = stall_now;
  end

  // Stall counter: a new stall is only armed from idle; a running one ignores new requests.
  always_comb begin
    scnt_d = 2'd0;
    if (scnt_q != 2'd0) begin
      scnt_d = scnt_q - 2'd1;
    end else if (!bus.wrt_IF_ID) begin
      scnt_d = stall_len - 2'd1;
    end
  end

  // PC and IF/ID next state; priority stall > redirect > halted > normal fetch.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_inc_d = pc_inc_q;
    valid_d  = valid_q;
    halt_d   = halt_q;
    if (stall_now) begin
      // Hold everything.
    end else if (bus.br_taken) begin
      pc_d     = bus.br_target;
      instr_d  = NOP_INSTR;
      pc_inc_d = '0;
      valid_d  = 1'b0;
    end else if (halt_q) begin
      instr_d  = NOP_INSTR;
      pc_inc_d = '0;
      valid_d  = 1'b0;
    end else begin
      instr_d  = bus.imem_data;
      pc_inc_d = pc_plus2;
      valid_d  = 1'b1;
      if (is_halt) begin
        // HALT enters IF/ID, but the PC stays on it.
        halt_d = 1'b1;
      end else begin
        pc_d   = pc_plus2;
      end
    end
  end

  // State registers with synchronous reset; reset also aborts any stall in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      scnt_q   <= 2'd0;
      instr_q  <= NOP_INSTR;
      pc_inc_q <= '0;
      valid_q  <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      scnt_q   <= scnt_d;
      instr_q  <= instr_d;
      pc_inc_q <= pc_inc_d;
      valid_q  <= valid_d;
      halt_q   <= halt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    bus.instr_IF_ID  = instr_q;
    bus.pc_inc_IF_ID = pc_inc_q;
    bus.valid_IF_ID  = valid_q;
    bus.halt_fetch   = halt_q;
  end

endmodule

// File: tb/tb_fetch_if_id.sv
// Directed bench for fetch_if_id: sequential fetch, stalls of each length, redirects,
// redirect during stall, HALT and reset recovery.
module tb_fetch_if_id;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic halt_en;

  fetch_if_id_if #(.PC_W(16), .INSTR_W(16)) bus ();

  fetch_if_id #(
    .PC_W      (16),
    .INSTR_W   (16),
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: word at address A is 1000h + A; address 000Ah holds HALT when enabled.
  assign bus.imem_data = (halt_en && bus.imem_addr == 16'h000A) ? 16'h0000
                                                               : 16'h1000 + bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                          input logic [15:0] pinc, input logic valid);
    chk({tag, ".addr"},  bus.imem_addr, addr);
    chk({tag, ".instr"}, bus.instr_IF_ID, instr);
    if (valid) chk({tag, ".pinc"}, bus.pc_inc_IF_ID, pinc);
    chk({tag, ".valid"}, 16'(bus.valid_IF_ID), 16'(valid));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    halt_en  = 1'b0;
    rst      = 1'b1;
    bus.stall_c   = 2'b00;
    bus.wrt_IF_ID = 1'b1;
    bus.br_taken  = 1'b0;
    bus.br_target = 16'h0000;

    // Reset state
    tick();
    chk("rst.addr",   bus.imem_addr, 16'h0000);
    chk("rst.instr",  bus.instr_IF_ID, 16'h0800);
    chk("rst.pinc",   bus.pc_inc_IF_ID, 16'h0000);
    chk("rst.valid",  16'(bus.valid_IF_ID), 16'd0);
    chk("rst.halt",   16'(bus.halt_fetch), 16'd0);
    chk("rst.en",     16'(bus.imem_en), 16'd0);

    // Sequential fetch
    rst = 1'b0;
    #1;
    chk("seq.en",     16'(bus.imem_en), 16'd1);
    chk("seq.bubble", 16'(bus.bubble_ID), 16'd0);
    tick(); chk_ifid("seq0", 16'h0002, 16'h1000, 16'h0002, 1'b1);
    tick(); chk_ifid("seq1", 16'h0004, 16'h1002, 16'h0004, 1'b1);
    tick(); chk_ifid("seq2", 16'h0006, 16'h1004, 16'h0006, 1'b1);

    // One-cycle stall at pc 6
    bus.wrt_IF_ID = 1'b0;
    bus.stall_c   = 2'b01;
    #1;
    chk("st1.bubble", 16'(bus.bubble_ID), 16'd1);
    chk("st1.en",     16'(bus.imem_en), 16'd0);
    tick(); chk_ifid("st1.hold", 16'h0006, 16'h1004, 16'h0006, 1'b1);
    bus.wrt_IF_ID = 1'b1;
    #1;
    chk("st1.release", 16'(bus.bubble_ID), 16'd0);
    tick(); chk_ifid("st1.adv", 16'h0008, 16'h1006, 16'h0008, 1'b1);

    // Two-cycle stall with request held for both cycles: must not re-trigger
    bus.wrt_IF_ID = 1'b0;
    bus.stall_c   = 2'b10;
    tick(); chk_ifid("st2.c1", 16'h0008, 16'h1006, 16'h0008, 1'b1);
    chk("st2.c2bubble", 16'(bus.bubble_ID), 16'd1);
    tick(); chk_ifid("st2.c2", 16'h0008, 16'h1006, 16'h0008, 1'b1);
    bus.wrt_IF_ID = 1'b1;
    #1;
    chk("st2.noretrig", 16'(bus.bubble_ID), 16'd0);
    tick(); chk_ifid("st2.adv", 16'h000A, 16'h1008, 16'h000A, 1'b1);

    // Redirect with no stall
    bus.br_taken  = 1'b1;
    bus.br_target = 16'h0040;
    tick(); chk_ifid("br.flush", 16'h0040, 16'h0800, 16'h0000, 1'b0);
    bus.br_taken = 1'b0;
    tick(); chk_ifid("br.next", 16'h0042, 16'h1040, 16'h0042, 1'b1);

    // Redirect during a stall is ignored
    bus.wrt_IF_ID = 1'b0;
    bus.stall_c   = 2'b01;
    bus.br_taken  = 1'b1;
    bus.br_target = 16'h0080;
    tick(); chk_ifid("brst.hold", 16'h0042, 16'h1040, 16'h0042, 1'b1);
    bus.wrt_IF_ID = 1'b1;
    bus.br_taken  = 1'b0;
    tick(); chk_ifid("brst.noredir", 16'h0044, 16'h1042, 16'h0044, 1'b1);
    bus.br_taken = 1'b1;
    tick(); chk_ifid("brst.redir", 16'h0080, 16'h0800, 16'h0000, 1'b0);
    bus.br_taken = 1'b0;

    // Three-cycle stall
    bus.wrt_IF_ID = 1'b0;
    bus.stall_c   = 2'b11;
    tick();
    bus.wrt_IF_ID = 1'b1;
    #1;
    chk("st3.c2bubble", 16'(bus.bubble_ID), 16'd1);
    tick();
    chk("st3.c3bubble", 16'(bus.bubble_ID), 16'd1);
    chk("st3.c3addr",   bus.imem_addr, 16'h0080);
    tick();
    chk("st3.done",     16'(bus.bubble_ID), 16'd0);
    chk("st3.addr",     bus.imem_addr, 16'h0080);
    tick(); chk_ifid("st3.adv", 16'h0082, 16'h1080, 16'h0082, 1'b1);

    // HALT at 000A
    bus.br_taken  = 1'b1;
    bus.br_target = 16'h000A;
    tick();
    bus.br_taken = 1'b0;
    halt_en      = 1'b1;
    #1;
    chk("halt.preen", 16'(bus.imem_en), 16'd1);
    tick(); chk_ifid("halt.load", 16'h000A, 16'h0000, 16'h000C, 1'b1);
    chk("halt.flag",  16'(bus.halt_fetch), 16'd1);
    chk("halt.en",    16'(bus.imem_en), 16'd0);
    tick(); chk_ifid("halt.after", 16'h000A, 16'h0800, 16'h0000, 1'b0);
    chk("halt.sticky", 16'(bus.halt_fetch), 16'd1);

    // Reset clears HALT
    rst     = 1'b1;
    halt_en = 1'b0;
    tick();
    chk("rst2.addr", bus.imem_addr, 16'h0000);
    chk("rst2.halt", 16'(bus.halt_fetch), 16'd0);
    rst = 1'b0;
    tick(); chk_ifid("rst2.fetch", 16'h0002, 16'h1000, 16'h0002, 1'b1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
